// File: rtl/debug_rx_loader_pkg.sv
`default_nettype none
// ============================================================================
// debug_rx_loader_pkg : shared debug-path types and constants
// Rev 1.0
// ============================================================================
package debug_rx_loader_pkg;

    localparam int          DEFAULT_CLKS_PER_BIT = 868;
    localparam logic [31:0] HALT_WORD            = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/debug_rx_loader_if.sv
`default_nettype none
// ============================================================================
// debug_rx_loader_if : instruction-memory write port of the program loader
// Rev 1.0
// ============================================================================
interface debug_rx_loader_if #(
    parameter int ADDR_W = 8
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface
`default_nettype wire

// File: rtl/debug_rx_loader_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// uart_rx_byte : 8N1 receiver with rx synchroniser and mid-bit sampling
// Rev 1.0
// ============================================================================
module uart_rx_byte
    import debug_rx_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       rx,
    output logic            start_ok,
    output logic            byte_valid,
    output logic [7:0]      byte_data,
    output logic            frame_err
);
    localparam int                c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [1:0]         r_sync;
    logic               r_rx_prev;
    rx_state_t          r_state, w_state_n;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_n;
    logic [2:0]         r_bit, w_bit_n;
    logic [7:0]         r_shift, w_shift_n;
    logic               r_valid, w_valid_n;
    logic               r_ferr, w_ferr_n;
    logic               r_start, w_start_n;
    logic               w_rx;

    assign w_rx = r_sync[1];

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_valid <= w_valid_n;
            r_ferr  <= w_ferr_n;
            r_start <= w_start_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_valid_n = 1'b0;
        w_ferr_n  = 1'b0;
        w_start_n = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_n = '0;
                if (r_rx_prev && !w_rx)
                    w_state_n = RX_START;
            end
            RX_START: begin
                if (r_cnt == c_half) begin
                    w_cnt_n = '0;
                    if (w_rx) begin
                        w_state_n = RX_IDLE;
                    end else begin
                        w_state_n = RX_DATA;
                        w_bit_n   = '0;
                        w_start_n = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (r_cnt == c_full) begin
                    w_cnt_n   = '0;
                    w_shift_n = {w_rx, r_shift[7:1]};
                    w_bit_n   = r_bit + 1'b1;
                    if (r_bit == 3'd7)
                        w_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                // Returning to idle at mid-stop lets a back-to-back start bit be seen.
                if (r_cnt == c_full) begin
                    w_cnt_n   = '0;
                    w_state_n = RX_IDLE;
                    w_valid_n = w_rx;
                    w_ferr_n  = !w_rx;
                end
            end
            default: w_state_n = RX_IDLE;
        endcase
    end

    assign start_ok   = r_start;
    assign byte_valid = r_valid;
    assign byte_data  = r_shift;
    assign frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: rtl/debug_rx_loader.sv
`default_nettype none
// ============================================================================
// debug_rx_loader : UART program loader writing MSB-first words to imem
// Optional build macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte). Rev 1.0
// ============================================================================
module debug_rx_loader
    import debug_rx_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = 8,
    parameter int MAX_WORDS    = 256
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          rx,
    debug_rx_loader_if.master  imem,
    output logic               loading,
    output logic               load_done,
    output logic               mips_enable,
    output logic               frame_err,
    output logic [ADDR_W:0]    word_count
);
    localparam logic [ADDR_W:0] c_last_addr = (ADDR_W + 1)'(MAX_WORDS - 1);

    logic          w_start, w_byte_valid, w_byte_ferr;
    logic [7:0]    w_byte;

    loader_state_t r_state, w_state_n;
    logic [1:0]    r_byte_cnt;
    logic [23:0]   r_word;
    logic [31:0]   w_word_n;
    logic [ADDR_W-1:0] r_addr, r_waddr;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic [ADDR_W:0] r_word_count;
    logic          r_frame_err, r_loading, r_load_done;
    logic          w_accept, w_write, w_last;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    r_csum;
    logic          r_csum_ok, r_mips_en, w_csum_hit;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .start_ok   (w_start),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte),
        .frame_err  (w_byte_ferr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_accept  = 1'b0;
        w_write   = 1'b0;
        w_word_n  = {r_word, w_byte};
        w_last    = (w_word_n == HALT_WORD) || ({1'b0, r_addr} == c_last_addr);
`ifdef LOADER_CHECKSUM_EN
        w_csum_hit = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_accept = w_byte_valid;
                if (w_start || w_byte_valid)
                    w_state_n = ST_LOAD;
            end
            ST_LOAD: begin
                w_accept = w_byte_valid;
                if (w_byte_valid && r_byte_cnt == 2'd3) begin
                    w_write = 1'b1;
                    if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                        w_state_n = ST_CHECK;
`else
                        w_state_n = ST_DONE;
`endif
                    end
                end
            end
            ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_byte_valid) begin
                    w_state_n  = ST_DONE;
                    w_csum_hit = (w_byte == r_csum);
                end else if (w_byte_ferr) begin
                    w_state_n  = ST_DONE;
                end
`else
                w_state_n = ST_DONE;
`endif
            end
            ST_DONE: w_state_n = ST_DONE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_addr       <= '0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_word_count <= '0;
            r_frame_err  <= 1'b0;
            r_loading    <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_word     <= w_word_n[23:0];
            end
            // A bad stop bit discards whatever part of the word was collected.
            if (w_byte_ferr && (r_state == ST_IDLE || r_state == ST_LOAD))
                r_byte_cnt <= '0;
            r_we <= w_write;
            if (w_write) begin
                r_wdata      <= w_word_n;
                r_waddr      <= r_addr;
                r_word_count <= r_word_count + 1'b1;
                if (!w_last)
                    r_addr <= r_addr + 1'b1;
            end
            r_frame_err <= r_frame_err | w_byte_ferr;
            if (r_state == ST_DONE) begin
                r_loading   <= 1'b0;
                r_load_done <= 1'b1;
            end else if (r_state == ST_IDLE && w_state_n == ST_LOAD) begin
                r_loading <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum    <= '0;
            r_csum_ok <= 1'b0;
            r_mips_en <= 1'b0;
        end else begin
            if (w_accept)
                r_csum <= r_csum ^ w_byte;
            if (w_csum_hit)
                r_csum_ok <= 1'b1;
            r_mips_en <= r_mips_en | ((r_state == ST_DONE) && r_csum_ok);
        end
    end
    assign mips_enable = r_mips_en;
`else
    assign mips_enable = r_load_done;
`endif

    assign imem.imem_we    = r_we;
    assign imem.imem_addr  = r_waddr;
    assign imem.imem_wdata = r_wdata;
    assign loading         = r_loading;
    assign load_done       = r_load_done;
    assign frame_err       = r_frame_err;
    assign word_count      = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_debug_rx_loader.sv
`default_nettype none
// ============================================================================
// tb_debug_rx_loader : directed self-checking bench for debug_rx_loader
// Rev 1.0
// ============================================================================
module tb_debug_rx_loader;
    import debug_rx_loader_pkg::*;

    localparam int CLKS   = 16;
    localparam int BIT_NS = CLKS * 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;

    logic       loading_a, load_done_a, mips_a, ferr_a;
    logic [8:0] wc_a;
    logic       loading_b, load_done_b, mips_b, ferr_b;
    logic [8:0] wc_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_we_a = -1;
    int done_cyc_a = -1;
    logic done_prev_a = 1'b0;

    logic [7:0]  wa_addr[$];
    logic [31:0] wa_data[$];
    logic [8:0]  wa_wc[$];
    logic [7:0]  wb_addr[$];
    logic [31:0] wb_data[$];

    debug_rx_loader_if #(.ADDR_W(8)) imem_a ();
    debug_rx_loader_if #(.ADDR_W(8)) imem_b ();

    debug_rx_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(8), .MAX_WORDS(256)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .imem(imem_a),
        .loading(loading_a), .load_done(load_done_a), .mips_enable(mips_a),
        .frame_err(ferr_a), .word_count(wc_a)
    );

    debug_rx_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(8), .MAX_WORDS(4)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .imem(imem_b),
        .loading(loading_b), .load_done(load_done_b), .mips_enable(mips_b),
        .frame_err(ferr_b), .word_count(wc_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            wa_addr.delete(); wa_data.delete(); wa_wc.delete();
            wb_addr.delete(); wb_data.delete();
            last_we_a  = -1;
            done_cyc_a = -1;
        end else begin
            if (imem_a.imem_we) begin
                wa_addr.push_back(imem_a.imem_addr);
                wa_data.push_back(imem_a.imem_wdata);
                wa_wc.push_back(wc_a);
                last_we_a = cyc;
            end
            if (imem_b.imem_we) begin
                wb_addr.push_back(imem_b.imem_addr);
                wb_data.push_back(imem_b.imem_wdata);
            end
            if (load_done_a && !done_prev_a)
                done_cyc_a = cyc;
        end
        done_prev_a = load_done_a;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic send_byte(input int which, input logic [7:0] b, input logic stop);
        set_rx(which, 1'b0);
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, b[i]);
            #(BIT_NS);
        end
        set_rx(which, stop);
        #(BIT_NS);
        set_rx(which, 1'b1);
        if (!stop) #(BIT_NS);
    endtask

    task automatic send_word(input int which, input logic [31:0] w);
        for (int i = 3; i >= 0; i--)
            send_byte(which, w[i*8 +: 8], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] qa_data(input int i);
        return (wa_data.size() > i) ? wa_data[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [7:0] qa_addr(input int i);
        return (wa_addr.size() > i) ? wa_addr[i] : 8'hEE;
    endfunction
    function automatic logic [8:0] qa_wc(input int i);
        return (wa_wc.size() > i) ? wa_wc[i] : 9'h1EE;
    endfunction

    initial begin
        int n_before;
        repeat (4) @(negedge clk);
        check_eq("rst_loading",   loading_a,         0);
        check_eq("rst_done",      load_done_a,       0);
        check_eq("rst_mips",      mips_a,            0);
        check_eq("rst_ferr",      ferr_a,            0);
        check_eq("rst_wc",        wc_a,              0);
        check_eq("rst_we",        imem_a.imem_we,    0);
        check_eq("rst_addr",      imem_a.imem_addr,  0);
        check_eq("rst_wdata",     imem_a.imem_wdata, 0);
        rst = 1'b0;

        // Short low glitch must be rejected as a false start.
        repeat (5) @(negedge clk);
        rx_a = 1'b0;
        #50;
        rx_a = 1'b1;
        #(3 * BIT_NS);
        check_eq("glitch_loading", loading_a, 0);
        check_eq("glitch_writes",  wa_data.size(), 0);

        // Reset in the middle of a word aborts the load.
        send_byte(0, 8'h20, 1'b1);
        send_byte(0, 8'h08, 1'b1);
        #(BIT_NS);
        check_eq("abort_loading_pre", loading_a, 1);
        n_before = wa_data.size();
        check_eq("abort_no_write", n_before, 0);
        rst = 1'b1;
        #20;
        check_eq("abort_we",      imem_a.imem_we, 0);
        check_eq("abort_loading", loading_a,      0);
        check_eq("abort_wc",      wc_a,           0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fresh load: program word then halt word.
        send_word(0, 32'h2008_0005);
        send_word(0, 32'h0000_0000);
        #(2 * BIT_NS);
`ifdef LOADER_CHECKSUM_EN
        send_byte(0, 8'h2D, 1'b1);
        #(2 * BIT_NS);
`endif
        check_eq("main_nwr",    wa_data.size(), 2);
        check_eq("main_addr0",  qa_addr(0), 0);
        check_eq("main_data0",  qa_data(0), 32'h2008_0005);
        check_eq("main_wc0",    qa_wc(0),   1);
        check_eq("main_addr1",  qa_addr(1), 1);
        check_eq("main_data1",  qa_data(1), 32'h0000_0000);
        check_eq("main_wc1",    qa_wc(1),   2);
        check_eq("main_wc",     wc_a,       2);
        check_eq("main_done",   load_done_a, 1);
        check_eq("main_loading", loading_a, 0);
        check_eq("main_mips",   mips_a,     1);
`ifndef LOADER_CHECKSUM_EN
        check_eq("main_done_lat", done_cyc_a, last_we_a + 1);
`endif
        send_word(0, 32'h1234_5678);
        #(BIT_NS);
        check_eq("after_done_nwr", wa_data.size(), 2);
        check_eq("after_done_wc",  wc_a, 2);

        // Framing error mid-word drops the partial word.
        do_reset();
        send_byte(0, 8'hAA, 1'b1);
        send_byte(0, 8'hBB, 1'b1);
        send_byte(0, 8'hCC, 1'b0);
        check_eq("ferr_flag",  ferr_a, 1);
        check_eq("ferr_nowr",  wa_data.size(), 0);
        send_word(0, 32'h1122_3344);
        send_word(0, 32'h0000_0000);
        #(2 * BIT_NS);
`ifdef LOADER_CHECKSUM_EN
        send_byte(0, 8'h56, 1'b1);
        #(2 * BIT_NS);
`endif
        check_eq("ferr_addr0", qa_addr(0), 0);
        check_eq("ferr_data0", qa_data(0), 32'h1122_3344);
        check_eq("ferr_addr1", qa_addr(1), 1);
        check_eq("ferr_wc",    wc_a, 2);
        check_eq("ferr_sticky", ferr_a, 1);
        check_eq("ferr_done",  load_done_a, 1);
`ifdef LOADER_CHECKSUM_EN
        check_eq("csum_bad_mips", mips_a, 0);

        do_reset();
        send_word(0, 32'h0102_0304);
        send_word(0, 32'h0000_0000);
        send_byte(0, 8'h04, 1'b1);
        #(2 * BIT_NS);
        check_eq("csum_ok_mips", mips_a, 1);
        check_eq("csum_ok_done", load_done_a, 1);

        do_reset();
        send_word(0, 32'h0102_0304);
        send_word(0, 32'h0000_0000);
        send_byte(0, 8'h05, 1'b1);
        #(2 * BIT_NS);
        check_eq("csum_bad2_mips", mips_a, 0);
        check_eq("csum_bad2_done", load_done_a, 1);
`else
        check_eq("ferr_mips", mips_a, 1);
`endif

        // Memory-full termination with MAX_WORDS = 4.
        do_reset();
        for (int w = 1; w <= 5; w++)
            send_word(1, {4{w[7:0]}});
        #(2 * BIT_NS);
        check_eq("full_nwr", wb_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] k;
            k = 8'(i + 1);
            check_eq($sformatf("full_addr%0d", i), (wb_addr.size() > i) ? wb_addr[i] : 8'hEE, i);
            check_eq($sformatf("full_data%0d", i), (wb_data.size() > i) ? wb_data[i] : 32'hDEAD_BEEF, {4{k}});
        end
        check_eq("full_wc",   wc_b, 4);
        check_eq("full_done", load_done_b, 1);
        check_eq("full_loading", loading_b, 0);
`ifndef LOADER_CHECKSUM_EN
        check_eq("full_mips", mips_b, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
